secret_bus_if: RTL

CPU-side bus interface for the Mr. Do! protection PAL (U001) model. Snoops the Z80 bus and turns each completed write into the $8800-$8FFF text-RAM window into a one-cycle clock-enable plus a stable challenge byte for the PAL. It also decodes reads of $9803 (SECRE) and returns the PAL response to the CPU data mux. It sits between the Z80 core/address decoder and the PAL responder. An optional trace ring records recent challenge/response pairs for debug.

---
 rtl/secret_bus_if.sv | 137 +++++++++++++
 1 files changed

// File: rtl/secret_bus_if.sv
// rtl/secret_bus_if.sv - Z80 bus snoop for the Mr. Do! protection PAL: text-RAM write strobes and SECRE reads.
// Optional debug trace ring of challenge/response pairs enabled by SECRET_TRACE_EN.
module secret_bus_if #(
  parameter int MIN_WR_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_dout,
  input  logic        cpu_mreq_n,
  input  logic        cpu_wr_n,
  input  logic        cpu_rd_n,
  input  logic [7:0]  pal_dout,
  output logic [7:0]  pal_din,
  output logic        pal_ce,
  output logic        rd_sel,
  output logic [7:0]  rd_data,
  output logic [7:0]  chal_cnt,
  input  logic [1:0]  dbg_idx,
  output logic [15:0] dbg_data,
  output logic [2:0]  dbg_count
);

  typedef enum logic [1:0] {IDLE, WR_ACT, STROBE, RD_ACT} state_t;

  localparam logic [3:0] MIN_RUN = 4'(MIN_WR_CYCLES);

  state_t      r_state;
  logic [3:0]  r_run;
  logic [7:0]  r_hold;
  logic [7:0]  r_pal_din;
  logic        r_pal_ce;
  logic        r_rd_sel;
  logic [7:0]  r_rd_data;
  logic [7:0]  r_chal_cnt;

  logic w_qw;
  logic w_qr;

  assign w_qw = !cpu_mreq_n && !cpu_wr_n && (cpu_addr[15:11] == 5'b10001);
  assign w_qr = !cpu_mreq_n && !cpu_rd_n && (cpu_addr == 16'h9803);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_run      <= 4'd0;
      r_hold     <= 8'd0;
      r_pal_din  <= 8'd0;
      r_pal_ce   <= 1'b0;
      r_rd_sel   <= 1'b0;
      r_rd_data  <= 8'd0;
      r_chal_cnt <= 8'd0;
    end else begin
      r_pal_ce <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_qw) begin
            r_state <= WR_ACT;
            r_run   <= 4'd1;
            r_hold  <= cpu_dout;
          end else if (w_qr) begin
            r_state   <= RD_ACT;
            r_rd_sel  <= 1'b1;
            r_rd_data <= pal_dout;
          end
        end
        WR_ACT: begin
          if (w_qw) begin
            r_hold <= cpu_dout;
            if (r_run != 4'd15) r_run <= r_run + 4'd1;
          end else if (r_run >= MIN_RUN) begin
            // Too-short runs are bus glitches and are dropped silently.
            r_state    <= STROBE;
            r_pal_ce   <= 1'b1;
            r_pal_din  <= r_hold;
            r_chal_cnt <= r_chal_cnt + 8'd1;
          end else begin
            r_state <= IDLE;
          end
        end
        STROBE: begin
          r_state <= IDLE;
        end
        RD_ACT: begin
          if (w_qr) begin
            r_rd_data <= pal_dout;
          end else begin
            r_rd_sel <= 1'b0;
            r_state  <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign pal_din  = r_pal_din;
  assign pal_ce   = r_pal_ce;
  assign rd_sel   = r_rd_sel;
  assign rd_data  = r_rd_data;
  assign chal_cnt = r_chal_cnt;

`ifdef SECRET_TRACE_EN
  logic        r_ce_d;
  logic [15:0] r_ring [4];
  logic [1:0]  r_wp;
  logic [2:0]  r_cnt;
  logic [1:0]  w_rd_ptr;

  // The PAL answers one cycle after pal_ce, so the pair is logged a cycle later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ce_d <= 1'b0;
      r_wp   <= 2'd0;
      r_cnt  <= 3'd0;
      for (int i = 0; i < 4; i++) r_ring[i] <= 16'h0000;
    end else begin
      r_ce_d <= r_pal_ce;
      if (r_ce_d) begin
        r_ring[r_wp] <= {r_pal_din, pal_dout};
        r_wp         <= r_wp + 2'd1;
        if (r_cnt != 3'd4) r_cnt <= r_cnt + 3'd1;
      end
    end
  end

  assign w_rd_ptr  = r_wp - 2'd1 - dbg_idx;
  assign dbg_data  = r_ring[w_rd_ptr];
  assign dbg_count = r_cnt;
`else
  logic w_unused_dbg;
  assign w_unused_dbg = ^dbg_idx;
  assign dbg_data     = 16'h0000;
  assign dbg_count    = 3'd0;
`endif

endmodule
